muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multicycle multiply/divide controller for the single-cycle MIPS core. It owns the HI/LO special registers and sequences a one-bit-per-cycle shift-add multiplier and a restoring divider for mult, multu, div and divu. While an operation runs it raises a stall so the core holds PC on dependent HI/LO traffic. The core's ALU path is untouched: operands come from the register-file read ports (srca, writedata), and mfhi/mflo results return through the result mux.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  decoder issues mult/multu/div/divu this cycle.
- op  in  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- srca  in  WIDTH  rs value: multiplicand, dividend, or mthi/mtlo data.
- srcb  in  WIDTH  rt value: multiplier or divisor.
- mthi  in  1  write srca to HI.
- mtlo  in  1  write srca to LO.
- rdhilo  in  1  decoder issues mfhi/mflo this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in progress.
- stall  out  1  hold PC and suppress regwrite this cycle.
- done  out  1  one-cycle pulse when HI/LO receive a new result.
- divzero  out  1  last completed division had a zero divisor.

## Operation
- States: IDLE, CALC, SIGN. busy = (state != IDLE).
- IDLE with start=1:
  - Latch op and the sign flags.
  - Latch the operands: for mult/div, the absolute values of srca and srcb; otherwise the raw values.
  - Clear count and go to CALC. Clear divzero.
- CALC, multiply: 2*WIDTH+1-bit accumulator {carry, upper, multiplier}. Each cycle, if the LSB is 1, add the multiplicand into {carry, upper}; then shift the whole accumulator right by one.
- CALC, divide (restoring):
  - Each cycle, shift {rem, quot} left by one.
  - Compute the WIDTH+1-bit trial rem - divisor.
  - If the trial is non-negative, rem takes the trial and quot LSB becomes 1.
- CALC exit: count increments each cycle; after WIDTH iterations go to SIGN.
- SIGN, general rules:
  - Commit HI/LO, pulse done, go to IDLE.
  - mult: negate the 2*WIDTH product if the operand signs differ. HI takes the upper half, LO the lower half.
  - div: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
  - Results: LO = quotient, HI = remainder.
- SIGN, divide by zero (divu/div with divisor 0): LO = all ones, HI = original srca as latched raw, divzero = 1.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- mthi/mtlo in IDLE without start: write srca on the clock edge. start wins over mthi/mtlo in the same cycle.
- HI/LO change only on SIGN commit, mthi/mtlo, or reset. Working registers are separate, so HI/LO hold their old values during CALC.
- stall = busy & (start | rdhilo | mthi | mtlo), combinational.
  - While stalled, start/mthi/mtlo are ignored; the core re-presents the instruction.
  - The core does not re-present a start the cycle after a stall releases unless the instruction is still in decode.

## Timing
- Reset values: hi=0, lo=0, busy=0, stall=0, done=0, divzero=0, state IDLE.
- Reset mid-operation aborts with no HI/LO write and no done pulse.
- Per-operation timeline, with start sampled at edge N:
  - busy rises after edge N.
  - Edges N+1..N+WIDTH perform the iterations.
  - Edge N+WIDTH+1 (SIGN→IDLE) writes HI/LO.
  - done is high and busy low in the cycle after that edge.
- Total: WIDTH+1 busy cycles (33 for WIDTH=32); results are readable with no stall starting WIDTH+2 cycles after start is sampled.
- Back-to-back: a start in the cycle done is high is accepted (state is IDLE).
- Non-muldiv instructions never stall, even while busy.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. done asserts exactly 34 cycles after the start edge; busy is high for 33 cycles.
- mult 0xFFFFFFFD × 5: hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then div 0xFFFFFFF9 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100 / 0: lo=0xFFFFFFFF, hi=0x00000064, divzero=1. Then divu 7/3: lo=2, hi=1, divzero=0.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Pipeline interlock:
  - While busy, assert rdhilo, start and mthi: stall is high each cycle, and HI/LO are unchanged until commit.
  - After commit, mtlo 0x1234: lo=0x1234 on the next edge with no stall.
- Reset at cycle 10 of a divu:
  - All outputs go to 0 asynchronously, before the next edge.
  - A subsequent multu 3×4 gives lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// HI/LO owner for the MIPS core: sequences a shift-add multiplier and a restoring
// divider (one bit per cycle) and stalls dependent HI/LO traffic while busy.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo write HI/LO directly
// CALC  | WIDTH multiply or divide iterations on the working registers
// SIGN  | apply result signs, commit HI/LO, pulse done
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             rdhilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divzero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t state, state_n;

    logic [1:0]       op_q;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH:0] acc;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [2*WIDTH:0]   div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH:0]   div_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               div_by_zero;

    assign busy  = (state != IDLE);
    assign stall = busy & (start | rdhilo | mthi | mtlo);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CALC;
            CALC:    if (count == LAST) state_n = SIGN;
            SIGN:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Signed ops work on magnitudes; the signs are reapplied in SIGN.
    always_comb begin
        abs_a = (op[0] && srca[WIDTH-1]) ? -srca : srca;
        abs_b = (op[0] && srcb[WIDTH-1]) ? -srcb : srcb;
    end

    always_comb begin
        mul_sum   = {acc[2*WIDTH], acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {1'b0, mul_sum, acc[WIDTH-1:1]};

        div_shift = {acc[2*WIDTH-1:0], 1'b0};
        div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd};
        if (div_trial[WIDTH])
            div_next = {1'b0, div_shift[2*WIDTH-1:0]};
        else
            div_next = {1'b0, div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    end

    always_comb begin
        div_by_zero = (opnd == '0);
        prod_s = (op_q[0] && (neg_a ^ neg_b)) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        quot_s = (op_q[0] && (neg_a ^ neg_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s  = (op_q[0] && neg_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        if (op_q[1]) begin
            if (div_by_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            divzero <= 1'b0;
            op_q    <= '0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            a_raw   <= '0;
            opnd    <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        neg_a   <= op[0] & srca[WIDTH-1];
                        neg_b   <= op[0] & srcb[WIDTH-1];
                        a_raw   <= srca;
                        // Multiply: multiplicand = |a|, multiplier in acc low half.
                        // Divide: divisor = |b|, dividend starts as the quotient half.
                        opnd    <= op[1] ? abs_b : abs_a;
                        acc     <= {1'b0, {WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        count   <= '0;
                        divzero <= 1'b0;
                    end else begin
                        if (mthi) hi <= srca;
                        if (mtlo) lo <= srca;
                    end
                end
                CALC: begin
                    acc   <= op_q[1] ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                SIGN: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                    if (op_q[1] && div_by_zero) divzero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
